// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DMEM_WIDTH       = 32;
    localparam int MAX_LOCK_DEFAULT = 4;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    // Fields are DMEM_WIDTH wide; the top's DATA_WIDTH must match it.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  owner;
        logic [DMEM_WIDTH-1:0] addr;
        logic [DMEM_WIDTH-1:0] wdata;
    } dmem_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_lock_arbiter2.sv
// ============================================================================
//  Module      : rr_lock_arbiter2
//  Description : Two-way round-robin arbiter with a bounded grant lock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_lock_arbiter2 #(
    parameter int MAX_LOCK  = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);

    localparam logic [CNT_WIDTH-1:0] LOCK_MAX = CNT_WIDTH'(MAX_LOCK);

    logic                 ptr_q, ptr_d;        // requester favoured on a tie
    logic                 own_vld_q, own_vld_d;
    logic                 own_q, own_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;        // consecutive grants held by the owner
    logic                 w_lock_act;
    logic                 w_any;
    logic                 w_win;

    always_comb begin
        gnt_o      = '0;
        w_any      = 1'b0;
        w_win      = ptr_q;
        ptr_d      = ptr_q;
        own_vld_d  = 1'b0;
        own_d      = own_q;
        cnt_d      = '0;
        w_lock_act = own_vld_q && req_i[own_q] && lock_i[own_q];

        if (w_lock_act) begin
            w_any = 1'b1;
            if ((cnt_q == LOCK_MAX) && req_i[~own_q]) begin
                w_win = ~own_q;
            end else begin
                w_win = own_q;
            end
        end else if (req_i[0] && req_i[1]) begin
            w_any = 1'b1;
            w_win = ptr_q;
        end else if (req_i[0]) begin
            w_any = 1'b1;
            w_win = 1'b0;
        end else if (req_i[1]) begin
            w_any = 1'b1;
            w_win = 1'b1;
        end

        if (w_any) begin
            gnt_o[w_win] = 1'b1;
            ptr_d        = ~w_win;
            // The grant that establishes ownership counts as the first of the run.
            if (lock_i[w_win]) begin
                own_vld_d = 1'b1;
                own_d     = w_win;
                if (own_vld_q && (own_q == w_win)) begin
                    cnt_d = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_d = CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= 1'b0;
            own_vld_q <= 1'b0;
            own_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            own_vld_q <= own_vld_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_memory_arbiter.sv
// ============================================================================
//  Module      : data_memory_arbiter
//  Description : Core / loader arbiter and sequencer for the single-port data
//                memory. Optional counters: DATA_MEMORY_ARBITER_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_WIDTH,
    parameter int MAX_LOCK   = MAX_LOCK_DEFAULT,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DATA_MEMORY_ARBITER_PERF_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1,
    output logic [15:0]           stall_cnt0,
    output logic [15:0]           stall_cnt1
`endif
);

    dmem_cmd_t             cmd_q, cmd_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            w_gnt_raw;
    logic [1:0]            w_gnt;
    logic                  w_cmd_live;

    rr_lock_arbiter2 #(
        .MAX_LOCK  (MAX_LOCK),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  ({req1, req0}),
        .lock_i ({lock1, lock0}),
        .gnt_o  (w_gnt_raw)
    );

    // Outputs are forced low while reset is held so an in-flight write is dropped.
    assign w_gnt      = w_gnt_raw & {2{~reset}};
    assign w_cmd_live = cmd_q.valid & ~reset;

    always_comb begin
        cmd_d = '0;
        if (w_gnt[REQ_CORE]) begin
            cmd_d.valid = 1'b1;
            cmd_d.we    = we0;
            cmd_d.owner = REQ_CORE;
            cmd_d.addr  = addr0;
            cmd_d.wdata = wdata0;
        end else if (w_gnt[REQ_LOADER]) begin
            cmd_d.valid = 1'b1;
            cmd_d.we    = we1;
            cmd_d.owner = REQ_LOADER;
            cmd_d.addr  = addr1;
            cmd_d.wdata = wdata1;
        end
    end

    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (w_cmd_live && !cmd_q.we) begin
            rvalid_d[cmd_q.owner] = 1'b1;
            rdata_d               = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt0      = w_gnt[0];
    assign gnt1      = w_gnt[1];
    assign rvalid0   = rvalid_q[0] & ~reset;
    assign rvalid1   = rvalid_q[1] & ~reset;
    assign rdata     = rdata_q;
    assign mem_write = w_cmd_live & cmd_q.we;
    assign mem_read  = w_cmd_live & ~cmd_q.we;
    assign mem_addr  = w_cmd_live ? cmd_q.addr  : '0;
    assign mem_wdata = w_cmd_live ? cmd_q.wdata : '0;

`ifdef DATA_MEMORY_ARBITER_PERF_EN
    logic [15:0] grant_cnt0_q, grant_cnt1_q, stall_cnt0_q, stall_cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            stall_cnt0_q <= '0;
            stall_cnt1_q <= '0;
        end else begin
            if (w_gnt[0])          grant_cnt0_q <= sat_inc16(grant_cnt0_q);
            if (w_gnt[1])          grant_cnt1_q <= sat_inc16(grant_cnt1_q);
            if (req0 && !w_gnt[0]) stall_cnt0_q <= sat_inc16(stall_cnt0_q);
            if (req1 && !w_gnt[1]) stall_cnt1_q <= sat_inc16(stall_cnt1_q);
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign stall_cnt0 = stall_cnt0_q;
    assign stall_cnt1 = stall_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory in the MIPS datapath.
- Requester 0 is the core's load/store path; requester 1 is the debug/program loader.
- Arbitrates each cycle, registers the winning command, drives the memory's MemWrite/MemRead/Address/WriteData for one cycle, then returns the registered read data to the owner.
- Round-robin fairness, with an optional bounded lock for short bursts.

Parameters:
- DATA_WIDTH, 32, width of data words and of the memory address bus.
- MAX_LOCK, 4, maximum consecutive grants a locking requester keeps while the other requester is waiting.
- CNT_WIDTH, 3, width of the lock counter; must satisfy 2^CNT_WIDTH > MAX_LOCK.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  access request; held stable with its command until the matching gnt
- we0, we1  in  1 each  1 = write, 0 = read
- lock0, lock1  in  1 each  keep the grant for consecutive accesses (bounded by MAX_LOCK)
- addr0, addr1  in  DATA_WIDTH each  word address
- wdata0, wdata1  in  DATA_WIDTH each  write data
- gnt0, gnt1  out  1 each  combinational; request accepted this cycle
- rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata is valid for that requester
- rdata  out  DATA_WIDTH  registered read data, shared by both requesters
- mem_write  out  1  to memory MemWrite
- mem_read  out  1  to memory MemRead
- mem_addr  out  DATA_WIDTH  to memory Address
- mem_wdata  out  DATA_WIDTH  to memory WriteData
- mem_rdata  in  DATA_WIDTH  from memory ReadData; combinational, already gated by MemRead

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Round-robin pointer favours requester 0.
  - Lock owner cleared; lock counter 0; command stage and response stage invalid.
- Pipeline, for a request accepted in cycle T:
  - T: gnt high.
  - T+1: command register drives mem_*; mem_read = !we, mem_write = we; a write commits at the end of T+1.
  - T+2: for a read, rdata = mem_rdata as sampled at the end of T+1, and rvalidN = 1. Writes produce no rvalid.
  - One new grant is possible every cycle; back-to-back accesses are fully pipelined.
- Idle: when the command stage is empty, mem_write = 0, mem_read = 0, mem_addr = 0, mem_wdata = 0.
- Arbitration, evaluated each cycle; at most one gnt high:
  - Only one request: grant it.
  - Both request, lock not active: grant the requester not granted last. The pointer updates only on a grant.
  - Lock active (owner set, owner's req and lock both high, counter < MAX_LOCK): grant the owner and increment the counter.
  - Counter == MAX_LOCK with the other requester waiting: force a grant to the other requester; counter resets to 0.
  - Other requester not waiting: the owner keeps the grant; the counter saturates at MAX_LOCK.
  - Owner set on a grant with lock high; cleared when the owner's lock drops or the owner loses the grant. Counter resets on owner change.
- Width rules: mem_addr is passed through unmodified; the memory applies its own depth. No address translation or alignment check.
- Reset mid-operation: the command in flight is dropped. No mem_write in the following cycle; a pending rvalid is never issued.
- A requester that deasserts req before gnt loses its request silently (protocol violation, not detected).

Optional Feature:
- Macro: DATA_MEMORY_ARBITER_PERF_EN.
- When defined, add the following outputs, cleared on reset, each 16 bits and saturating:
  - grant_cnt0, grant_cnt1: count grants per requester.
  - stall_cnt0, stall_cnt1: count cycles with reqN high and gntN low.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - requester index constants REQ_CORE = 0, REQ_LOADER = 1.
  - command struct typedef {valid, we, owner, addr, wdata}.
  - default MAX_LOCK constant.
- One natural sub-module, rr_lock_arbiter2: pointer, lock owner and counter, combinational gnt. The top holds the command stage and response stage.

Test Plan:
- Single read: preload mem[0x10] = 0xDEADBEEF; req0 read addr 0x10 at T → gnt0 at T, mem_read = 1 and mem_addr = 0x10 at T+1, rvalid0 = 1 and rdata = 0xDEADBEEF at T+2.
- Contention: req0 and req1 both held, no lock, for 6 cycles after reset → grants alternate 0,1,0,1,0,1; stall counts 3/3 with PERF_EN.
- Lock bound: lock0 = 1 with req0 and req1 held, MAX_LOCK = 4 → 4 grants to 0, then 1 grant to 1, then back to 0.
- Write-then-read: req1 write addr 0x20 data 0x12345678 at T, req0 read 0x20 at T+1 → rvalid0 at T+3 with rdata = 0x12345678.
- Reset mid-flight: req0 write addr 0x30 data 0xAAAA5555 granted at T, reset high at T+1 → mem_write = 0 at T+1, mem[0x30] unchanged, all outputs 0 at T+2.
- Idle: no requests for 10 cycles → mem_read = mem_write = 0, no gnt, no rvalid.
